// File: rtl/hash_process_param_pkg.sv
// Shared SHA-256 constants, helper functions and FSM state type for the
// parametrised block processor.
package hash_process_param_pkg;

    typedef enum logic [1:0] {
        ST_READY,
        ST_ROUND,
        ST_UPDATE,
        ST_HOLD
    } state_t;

    localparam logic [31:0] K [0:63] = '{
        32'h428a2f98, 32'h71374491, 32'hb5c0fbcf, 32'he9b5dba5,
        32'h3956c25b, 32'h59f111f1, 32'h923f82a4, 32'hab1c5ed5,
        32'hd807aa98, 32'h12835b01, 32'h243185be, 32'h550c7dc3,
        32'h72be5d74, 32'h80deb1fe, 32'h9bdc06a7, 32'hc19bf174,
        32'he49b69c1, 32'hefbe4786, 32'h0fc19dc6, 32'h240ca1cc,
        32'h2de92c6f, 32'h4a7484aa, 32'h5cb0a9dc, 32'h76f988da,
        32'h983e5152, 32'ha831c66d, 32'hb00327c8, 32'hbf597fc7,
        32'hc6e00bf3, 32'hd5a79147, 32'h06ca6351, 32'h14292967,
        32'h27b70a85, 32'h2e1b2138, 32'h4d2c6dfc, 32'h53380d13,
        32'h650a7354, 32'h766a0abb, 32'h81c2c92e, 32'h92722c85,
        32'ha2bfe8a1, 32'ha81a664b, 32'hc24b8b70, 32'hc76c51a3,
        32'hd192e819, 32'hd6990624, 32'hf40e3585, 32'h106aa070,
        32'h19a4c116, 32'h1e376c08, 32'h2748774c, 32'h34b0bcb5,
        32'h391c0cb3, 32'h4ed8aa4a, 32'h5b9cca4f, 32'h682e6ff3,
        32'h748f82ee, 32'h78a5636f, 32'h84c87814, 32'h8cc70208,
        32'h90befffa, 32'ha4506ceb, 32'hbef9a3f7, 32'hc67178f2
    };

    localparam logic [31:0] IV256 [0:7] = '{
        32'h6a09e667, 32'hbb67ae85, 32'h3c6ef372, 32'ha54ff53a,
        32'h510e527f, 32'h9b05688c, 32'h1f83d9ab, 32'h5be0cd19
    };

    localparam logic [31:0] IV224 [0:7] = '{
        32'hc1059ed8, 32'h367cd507, 32'h3070dd17, 32'hf70e5939,
        32'hffc00b31, 32'h68581511, 32'h64f98fa7, 32'hbefa4fa4
    };

    function automatic logic [31:0] rotr(input logic [31:0] x, input int unsigned n);
        return (x >> n) | (x << (32 - n));
    endfunction

    function automatic logic [31:0] bsig0(input logic [31:0] x);
        return rotr(x, 2) ^ rotr(x, 13) ^ rotr(x, 22);
    endfunction

    function automatic logic [31:0] bsig1(input logic [31:0] x);
        return rotr(x, 6) ^ rotr(x, 11) ^ rotr(x, 25);
    endfunction

    function automatic logic [31:0] ssig0(input logic [31:0] x);
        return rotr(x, 7) ^ rotr(x, 18) ^ (x >> 3);
    endfunction

    function automatic logic [31:0] ssig1(input logic [31:0] x);
        return rotr(x, 17) ^ rotr(x, 19) ^ (x >> 10);
    endfunction

    function automatic logic [31:0] ch(input logic [31:0] x, input logic [31:0] y,
                                       input logic [31:0] z);
        return (x & y) ^ (~x & z);
    endfunction

    function automatic logic [31:0] maj(input logic [31:0] x, input logic [31:0] y,
                                        input logic [31:0] z);
        return (x & y) ^ (x & z) ^ (y & z);
    endfunction

endpackage

// File: rtl/hash_process_param_sha256_round.sv
// One combinational SHA-256 compression round. Working word 0 is 'a',
// word 7 is 'h'.
module sha256_round
    import hash_process_param_pkg::*;
(
    input  logic [255:0] work_i,
    input  logic [31:0]  k_i,
    input  logic [31:0]  w_i,
    output logic [255:0] work_o
);

    logic [7:0][31:0] wk;
    logic [7:0][31:0] nx;
    logic [31:0]      t1;
    logic [31:0]      t2;

    assign wk = work_i;

    // Compute T1/T2 and rotate the working variables by one position.
    always_comb begin
        t1    = wk[7] + bsig1(wk[4]) + ch(wk[4], wk[5], wk[6]) + k_i + w_i;
        t2    = bsig0(wk[0]) + maj(wk[0], wk[1], wk[2]);
        nx[0] = t1 + t2;
        nx[1] = wk[0];
        nx[2] = wk[1];
        nx[3] = wk[2];
        nx[4] = wk[3] + t1;
        nx[5] = wk[4];
        nx[6] = wk[5];
        nx[7] = wk[6];
    end

    assign work_o = nx;

endmodule

// File: rtl/hash_process_param.sv
// SHA-256 / SHA-224 block processor with configurable rounds per clock,
// per-message mode select and message ID passthrough.
module hash_process_param
    import hash_process_param_pkg::*;
#(
    parameter int unsigned ROUNDS_PER_CYCLE = 1,
    parameter int unsigned ID_W             = 4
) (
    input  logic            clk,
    input  logic            sync_rst,
    input  logic [511:0]    data_in,
    input  logic            data_in_last,
    input  logic            data_in_mode224,
    input  logic [ID_W-1:0] data_in_id,
    input  logic            data_in_valid,
    output logic            data_in_ready,
    output logic [255:0]    data_out,
    output logic [ID_W-1:0] data_out_id,
    output logic            data_out_mode224,
    output logic            data_out_last,
    output logic            data_out_valid,
    input  logic            data_out_ready
);

    localparam int unsigned R  = ROUNDS_PER_CYCLE;
    localparam logic [6:0]  R7 = 7'(ROUNDS_PER_CYCLE);

    if (!(R == 1 || R == 2 || R == 4 || R == 8)) begin : g_bad_rounds
        $error("hash_process_param: ROUNDS_PER_CYCLE must be 1, 2, 4 or 8");
    end

    state_t           state_q, state_d;
    logic             ready_q, ready_d;
    logic [7:0][31:0] h_q;
    logic [7:0][31:0] work_q;
    logic [7:0][31:0] h_sum;
    logic [7:0][31:0] iv_sel;
    logic [7:0][31:0] rnd_out;
    logic [7:0][31:0] out_src;
    logic [15:0][31:0] w_q;
    logic [15:0][31:0] w_next;
    logic [31:0]      ext [0:15+R];
    logic [6:0]       cnt_q;
    logic             first_q;
    logic             last_q;
    logic             mode_q;
    logic [ID_W-1:0]  id_q;
    logic [255:0]     out_q;
    logic [255:0]     out_data;
    logic [ID_W-1:0]  out_id_q;
    logic             out_mode_q;
    logic             out_valid_q;

    logic in_fire;
    logic rounds_done;
    logic slot_free;
    logic do_round;
    logic do_update;
    logic out_load;

    assign in_fire     = (state_q == ST_READY) && ready_q && data_in_valid;
    assign rounds_done = (cnt_q == 7'd64);
    assign slot_free   = !out_valid_q || data_out_ready;

    // Chain of R combinational rounds; round j consumes window word j.
    for (genvar j = 0; j < R; j++) begin : g_rnd
        logic [7:0][31:0] cur;
        logic [7:0][31:0] nxt;
        if (j == 0) begin : g_first
            assign cur = work_q;
        end else begin : g_chain
            assign cur = g_rnd[j-1].nxt;
        end
        sha256_round u_round (
            .work_i (cur),
            .k_i    (K[cnt_q[5:0] + 6'(j)]),
            .w_i    (w_q[j]),
            .work_o (nxt)
        );
    end
    assign rnd_out = g_rnd[R-1].nxt;

    // Extend the 16-word window by R schedule words, then drop the oldest R.
    // New words may depend on words generated earlier in the same cycle.
    always_comb begin
        for (int unsigned i = 0; i < 16; i++) begin
            ext[i] = w_q[i];
        end
        for (int unsigned i = 16; i < 16 + R; i++) begin
            ext[i] = ssig1(ext[i-2]) + ext[i-7] + ssig0(ext[i-15]) + ext[i-16];
        end
        for (int unsigned i = 0; i < 16; i++) begin
            w_next[i] = ext[i+R];
        end
    end

    // Chaining-value sum, IV choice and digest formatting.
    always_comb begin
        for (int unsigned i = 0; i < 8; i++) begin
            h_sum[i]  = h_q[i] + work_q[i];
            iv_sel[i] = data_in_mode224 ? IV224[i] : IV256[i];
        end
        out_src = (state_q == ST_UPDATE) ? h_sum : h_q;
        for (int unsigned i = 0; i < 8; i++) begin
            out_data[32*(7-i) +: 32] = out_src[i];
        end
        if (mode_q) begin
            out_data[31:0] = '0;
        end
    end

    // FSM state register and registered input-ready flag.
    always_ff @(posedge clk) begin
        if (sync_rst) begin
            state_q <= ST_READY;
            ready_q <= 1'b0;
        end else begin
            state_q <= state_d;
            ready_q <= ready_d;
        end
    end

    // FSM next-state logic.
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            ST_READY:  if (in_fire) state_d = ST_ROUND;
            ST_ROUND:  if (rounds_done) state_d = ST_UPDATE;
            ST_UPDATE: begin
                if (!last_q || slot_free) state_d = ST_READY;
                else                      state_d = ST_HOLD;
            end
            ST_HOLD:   if (slot_free) state_d = ST_READY;
        endcase
    end

    // FSM outputs: datapath enables and next value of input ready.
    always_comb begin
        do_round  = (state_q == ST_ROUND) && !rounds_done;
        do_update = (state_q == ST_UPDATE);
        out_load  = slot_free && (((state_q == ST_UPDATE) && last_q) || (state_q == ST_HOLD));
        ready_d   = (state_d == ST_READY);
    end

    // Working variables, schedule window, chaining value and message context.
    always_ff @(posedge clk) begin
        if (sync_rst) begin
            h_q     <= '0;
            work_q  <= '0;
            w_q     <= '0;
            cnt_q   <= '0;
            first_q <= 1'b1;
            last_q  <= 1'b0;
            mode_q  <= 1'b0;
            id_q    <= '0;
        end else begin
            if (in_fire) begin
                for (int unsigned i = 0; i < 16; i++) begin
                    w_q[i] <= data_in[32*(15-i) +: 32];
                end
                cnt_q  <= '0;
                last_q <= data_in_last;
                if (first_q) begin
                    h_q    <= iv_sel;
                    work_q <= iv_sel;
                    mode_q <= data_in_mode224;
                    id_q   <= data_in_id;
                end else begin
                    work_q <= h_q;
                end
            end
            if (do_round) begin
                work_q <= rnd_out;
                w_q    <= w_next;
                cnt_q  <= cnt_q + R7;
            end
            if (do_update) begin
                h_q     <= h_sum;
                first_q <= last_q;
            end
        end
    end

    // Output slot: holds a digest until the consumer accepts it; a new
    // digest may replace it on the accepting edge.
    always_ff @(posedge clk) begin
        if (sync_rst) begin
            out_q       <= '0;
            out_id_q    <= '0;
            out_mode_q  <= 1'b0;
            out_valid_q <= 1'b0;
        end else if (out_load) begin
            out_q       <= out_data;
            out_id_q    <= id_q;
            out_mode_q  <= mode_q;
            out_valid_q <= 1'b1;
        end else if (data_out_ready) begin
            out_valid_q <= 1'b0;
        end
    end

    assign data_in_ready    = ready_q;
    assign data_out         = out_q;
    assign data_out_id      = out_id_q;
    assign data_out_mode224 = out_mode_q;
    assign data_out_last    = out_valid_q;
    assign data_out_valid   = out_valid_q;

endmodule

// File: tb/tb_hash_process_param.sv
// Scoreboard bench: one DUT per legal ROUNDS_PER_CYCLE value (index d gives R = 1 << d).
module tb_hash_process_param;

    localparam logic [511:0] BLK_ABC   = {32'h61626380, 448'h0, 32'h00000018};
    localparam logic [511:0] BLK_EMPTY = {32'h80000000, 480'h0};
    localparam logic [511:0] BLK_TWO1  = {
        32'h61626364, 32'h62636465, 32'h63646566, 32'h64656667,
        32'h65666768, 32'h66676869, 32'h6768696a, 32'h68696a6b,
        32'h696a6b6c, 32'h6a6b6c6d, 32'h6b6c6d6e, 32'h6c6d6e6f,
        32'h6d6e6f70, 32'h6e6f7071, 32'h80000000, 32'h00000000};
    localparam logic [511:0] BLK_TWO2  = {480'h0, 32'h000001c0};

    localparam logic [255:0] DIG_ABC   = 256'hba7816bf8f01cfea414140de5dae2223b00361a396177a9cb410ff61f20015ad;
    localparam logic [255:0] DIG_EMPTY = 256'he3b0c44298fc1c149afbf4c8996fb92427ae41e4649b934ca495991b7852b855;
    localparam logic [255:0] DIG_TWO   = 256'h248d6a61d20638b8e5c026930c3e6039a33ce45964ff2167f6ecedd419db06c1;
    localparam logic [255:0] DIG_ABC224 = {224'h23097d223405d8228642a477bda255b32aadbce4bda0b3f7e36c9da7, 32'h0};

    typedef struct {
        int           dut;
        logic [255:0] dig;
        logic [3:0]   id;
        logic         mode;
    } exp_t;

    logic         clk = 1'b0;
    logic         rst;
    logic [511:0] din   [4];
    logic         dlast [4];
    logic         dmode [4];
    logic [3:0]   did   [4];
    logic         dval  [4];
    logic         irdy  [4];
    logic [255:0] dout  [4];
    logic [3:0]   doid  [4];
    logic         domode[4];
    logic         dolast[4];
    logic         doval [4];
    logic         ordy  [4];

    exp_t sbq[$];
    int   n_tests = 0;
    int   n_fail  = 0;

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [255:0] got, input logic [255:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    for (genvar g = 0; g < 4; g++) begin : g_dut
        exp_t e;
        hash_process_param #(.ROUNDS_PER_CYCLE(1 << g), .ID_W(4)) u_dut (
            .clk              (clk),
            .sync_rst         (rst),
            .data_in          (din[g]),
            .data_in_last     (dlast[g]),
            .data_in_mode224  (dmode[g]),
            .data_in_id       (did[g]),
            .data_in_valid    (dval[g]),
            .data_in_ready    (irdy[g]),
            .data_out         (dout[g]),
            .data_out_id      (doid[g]),
            .data_out_mode224 (domode[g]),
            .data_out_last    (dolast[g]),
            .data_out_valid   (doval[g]),
            .data_out_ready   (ordy[g])
        );

        // Output handshake happens at the next posedge: compare against the scoreboard.
        always @(negedge clk) begin
            if (!rst && doval[g] && ordy[g]) begin
                check("sb_nonempty", 256'(sbq.size() != 0), 1);
                if (sbq.size() != 0) begin
                    e = sbq.pop_front();
                    check("sb_dut", g, e.dut);
                    check("sb_digest", dout[g], e.dig);
                    check("sb_id", doid[g], e.id);
                    check("sb_mode", domode[g], e.mode);
                    check("sb_last", dolast[g], 1);
                end
            end
        end
    end

    task automatic expect_out(input int d, input logic [255:0] dig, input logic [3:0] id,
                              input logic mode);
        exp_t e;
        e.dut = d; e.dig = dig; e.id = id; e.mode = mode;
        sbq.push_back(e);
    endtask

    task automatic send_block(input int d, input logic [511:0] blk, input logic last,
                              input logic mode, input logic [3:0] id);
        int k = 0;
        din[d] = blk; dlast[d] = last; dmode[d] = mode; did[d] = id; dval[d] = 1'b1;
        do begin
            @(negedge clk);
            k++;
        end while (!irdy[d] && k < 300);
        check("in_handshake_timeout", 256'(irdy[d]), 1);
        @(posedge clk); #1;
        dval[d] = 1'b0;
    endtask

    task automatic wait_valid(input int d, input int exp_lat);
        int k = 0;
        do begin
            @(posedge clk); #1;
            k++;
        end while (!doval[d] && k < 300);
        check("lat_out_valid", k, exp_lat);
    endtask

    task automatic wait_ready(input int d, input int exp_lat);
        int k = 0;
        do begin
            @(posedge clk); #1;
            k++;
        end while (!irdy[d] && k < 300);
        check("lat_in_ready", k, exp_lat);
    endtask

    task automatic wait_cycles(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic check_reset(input int d);
        check("rst_in_ready", irdy[d], 0);
        check("rst_out_valid", doval[d], 0);
        check("rst_out_data", dout[d], 0);
        check("rst_out_id", doid[d], 0);
        check("rst_out_mode", domode[d], 0);
        check("rst_out_last", dolast[d], 0);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        rst = 1'b1;
        for (int d = 0; d < 4; d++) begin
            din[d] = '0; dlast[d] = 1'b0; dmode[d] = 1'b0; did[d] = '0;
            dval[d] = 1'b0; ordy[d] = 1'b1;
        end
        wait_cycles(3);
        for (int d = 0; d < 4; d++) check_reset(d);
        rst = 1'b0;
        wait_cycles(1);
        for (int d = 0; d < 4; d++) check("ready_after_reset", irdy[d], 1);

        // R=1, "abc", SHA-256
        expect_out(0, DIG_ABC, 4'd3, 1'b0);
        send_block(0, BLK_ABC, 1'b1, 1'b0, 4'd3);
        wait_valid(0, 66);
        wait_cycles(3);

        // R=8, empty message
        expect_out(3, DIG_EMPTY, 4'd0, 1'b0);
        send_block(3, BLK_EMPTY, 1'b1, 1'b0, 4'd0);
        wait_valid(3, 10);
        wait_cycles(3);

        // R=2, "abc", SHA-224
        expect_out(1, DIG_ABC224, 4'd6, 1'b1);
        send_block(1, BLK_ABC, 1'b1, 1'b1, 4'd6);
        wait_valid(1, 34);
        wait_cycles(3);

        // R=4, two-block message; second-block mode/id must be ignored
        expect_out(2, DIG_TWO, 4'd7, 1'b0);
        send_block(2, BLK_TWO1, 1'b0, 1'b0, 4'd7);
        wait_ready(2, 18);
        send_block(2, BLK_TWO2, 1'b1, 1'b1, 4'd2);
        wait_valid(2, 18);
        wait_cycles(3);

        // R=8 back-pressure: second digest waits in HOLD, then loads without a bubble
        ordy[3] = 1'b0;
        expect_out(3, DIG_ABC, 4'd1, 1'b0);
        send_block(3, BLK_ABC, 1'b1, 1'b0, 4'd1);
        wait_valid(3, 10);
        expect_out(3, DIG_EMPTY, 4'd5, 1'b0);
        send_block(3, BLK_EMPTY, 1'b1, 1'b0, 4'd5);
        wait_cycles(15);
        check("hold_in_ready", irdy[3], 0);
        check("hold_out_valid", doval[3], 1);
        check("hold_out_data", dout[3], DIG_ABC);
        check("hold_out_id", doid[3], 1);
        wait_cycles(3);
        check("hold_in_ready_stable", irdy[3], 0);
        check("hold_out_data_stable", dout[3], DIG_ABC);
        ordy[3] = 1'b1;
        wait_cycles(1);
        ordy[3] = 1'b0;
        check("nobubble_valid", doval[3], 1);
        check("nobubble_id", doid[3], 5);
        check("nobubble_data", dout[3], DIG_EMPTY);
        check("hold_exit_ready", irdy[3], 1);
        wait_cycles(2);
        check("slot_stable_valid", doval[3], 1);
        check("slot_stable_id", doid[3], 5);
        ordy[3] = 1'b1;
        wait_cycles(2);
        check("slot_drained", doval[3], 0);

        // R=1, reset in the middle of a non-last block
        send_block(0, BLK_TWO1, 1'b0, 1'b0, 4'd8);
        wait_cycles(20);
        rst = 1'b1;
        wait_cycles(1);
        check_reset(0);
        rst = 1'b0;
        wait_cycles(1);
        check("ready_after_mid_reset", irdy[0], 1);

        // first_block must be restored: "abc" alone gives its own digest
        expect_out(0, DIG_ABC, 4'd3, 1'b0);
        send_block(0, BLK_ABC, 1'b1, 1'b0, 4'd3);
        wait_valid(0, 66);
        wait_cycles(3);

        // Reset while an undelivered digest sits in the output slot
        ordy[0] = 1'b0;
        send_block(0, BLK_ABC, 1'b1, 1'b0, 4'd4);
        wait_valid(0, 66);
        rst = 1'b1;
        wait_cycles(1);
        check_reset(0);
        rst = 1'b0;
        ordy[0] = 1'b1;
        wait_cycles(1);

        expect_out(0, DIG_ABC, 4'd10, 1'b0);
        send_block(0, BLK_ABC, 1'b1, 1'b0, 4'd10);
        wait_valid(0, 66);
        wait_cycles(5);

        check("sb_drained", sbq.size(), 0);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/hash_process_param.md
Name: hash_process_param

Overview:
- Parametrised successor to the single-round SHA-256 block processor.
- Compresses 512-bit message blocks and emits SHA-256 or SHA-224 digests.
- Generalised in rounds-per-cycle unrolling, with a per-message mode select and a message ID carried from input to output.
- Sits between the block-padding front end and the digest output stage; valid/ready on both sides.

Parameters:
- ROUNDS_PER_CYCLE, 1, compression rounds per clock; legal values 1, 2, 4, 8; any other value is an elaboration error.
- ID_W, 4, width of the message ID carried from input to output.

Ports:
- clk, input, 1, clock.
- sync_rst, input, 1, synchronous active-high reset.
- data_in, input, 512, message block; word 0 in [511:480].
- data_in_last, input, 1, final block of the message.
- data_in_mode224, input, 1, 1 = SHA-224 (sampled on the first block of a message).
- data_in_id, input, ID_W, message ID (sampled on the first block of a message).
- data_in_valid, input, 1, input valid.
- data_in_ready, output, 1, input ready.
- data_out, output, 256, digest.
- data_out_id, output, ID_W, ID of the digested message.
- data_out_mode224, output, 1, mode of the digest.
- data_out_last, output, 1, constant 1 while valid.
- data_out_valid, output, 1, output valid.
- data_out_ready, input, 1, output ready.

Behaviour:
- Reset: while sync_rst is high at a clk edge, the block clears all state regardless of operation in progress; it returns to READY with first_block=1 and drops any partial message and any undelivered digest.
  - Output and status values under reset: data_in_ready=0, data_out_valid=0, data_out=0, data_out_id=0, data_out_mode224=0, data_out_last=0.
  - Internal registers under reset: H, a..h, W window and round counter all 0.
  - data_in_ready rises on the first cycle after reset is released.
- States: READY, ROUND, UPDATE, HOLD.
- READY (data_in_ready=1): on the handshake, load the W window with the 16 block words and load a..h from H.
  - If first_block, H and a..h come from IV256 or IV224 selected by data_in_mode224, and mode/ID are latched.
  - Also latch last_block, clear the round counter, drop ready and go to ROUND.
- ROUND: each cycle performs ROUNDS_PER_CYCLE chained rounds using rounds t..t+R-1 and K[t..]; counter advances by R.
  - Message schedule is a rolling 16-word window: rounds t<16 use block words; later words use W[t]=ssig1(W[t-2])+W[t-7]+ssig0(W[t-15])+W[t-16] mod 2^32.
  - The window shifts by R words per cycle. No 64-word array.
  - After 64/R cycles, go to UPDATE.
- UPDATE: H[i] <= H[i]+working[i] mod 2^32.
  - Not last: first_block=0, go to READY.
  - Last: first_block=1.
    - If the output slot is free (data_out_valid=0, or data_out_valid&&data_out_ready this cycle), load data_out/id/mode, assert valid and go to READY.
    - Otherwise go to HOLD.
- HOLD: load the output when the slot frees under the same rule, then go to READY. data_in_ready=0 while in HOLD.
- Output slot: data_out_valid stays high, with data_out/id/mode stable, until data_out_ready is sampled high. A new digest may load in the same cycle a handshake completes (no bubble).
- SHA-224 output: data_out[255:32]=H0..H6; data_out[31:0]=0.
- Latency, input handshake at edge N:
  - data_out_valid high after edge N+64/R+2 when the slot is free (66 cycles at R=1, 10 at R=8).
  - data_in_ready returns after edge N+64/R+2 for non-last blocks.
- Mode and ID on non-first blocks are ignored.
- data_in_valid while ready=0 has no effect; no combinational in-to-out paths.

Decomposition:
- Add K[0:63], IV256[0:7] and IV224[0:7] constant arrays to the existing hashing_functions package, alongside bsig0/bsig1/ssig0/ssig1/ch/maj.
- Sub-module sha256_round: combinational single round.
  - Inputs: a..h, K word, W word. Output: next a..h.
  - Instantiated ROUNDS_PER_CYCLE times in a generate chain.
- Schedule window update is done in-line.

Test Plan:
- R=1, one block "abc" padded, mode224=0, id=3 -> after 66 cycles, data_out = ba7816bf8f01cfea414140de5dae2223b00361a396177a9cb410ff61f20015ad, data_out_id=3.
- R=8, padded empty message, mode224=0 -> data_out = e3b0c44298fc1c149afbf4c8996fb92427ae41e4649b934ca495991b7852b855; valid 10 cycles after handshake.
- R=2, "abc", mode224=1 -> data_out = 23097d223405d8228642a477bda255b32aadbce4bda0b3f7e36c9da7_00000000, data_out_mode224=1.
- R=4, two-block "abcdbcdecdefdefgefghfghighijhijkijkljklmklmnlmnomnopnopq" -> data_out = 248d6a61d20638b8e5c026930c3e6039a33ce45964ff2167f6ecedd419db06c1. Second-block mode/id changes are ignored.
- Back-pressure: hold data_out_ready=0 while a second message (id=5) finishes -> block in HOLD with data_in_ready=0, first digest stable. Pulse ready for one cycle -> id=5 digest loads the same cycle, no bubble.
- Assert sync_rst mid-ROUND and again while data_out_valid=1 -> all outputs reset next cycle. Then "abc" gives the correct digest (first_block restored).
